mem_rd_responder: RTL and testbench

- Memory-side responder for the AFU core's DRAM read/write interface.
- Accepts read requests (valid + 58-bit cache-line address) and returns 512-bit responses in order, after a programmable latency.
- Absorbs cache-line writes into a local line store, and drives the almostfull backpressure the core samples.
- Sits at the far end of the rd/wr channels as a host/IO stand-in for block-level and integration testing.

---
 rtl/mem_rd_responder_if.sv | 22 ++
 rtl/mem_rd_responder.sv | 135 +++++++++++++
 tb/tb_mem_rd_responder.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_rd_responder_if.sv
// Read/write channel bundle between the AFU core (master) and the memory responder (slave).
interface mem_rd_responder_if;
  logic         rd_valid;
  logic [57:0]  rd_addr;
  logic         wr_valid;
  logic [57:0]  wr_addr;
  logic [511:0] wr_data;
  logic         rx_rd_valid;
  logic [511:0] rx_data;
  logic         tx_rd_almostfull;
  logic         tx_wr_almostfull;

  modport master (
    output rd_valid, rd_addr, wr_valid, wr_addr, wr_data,
    input  rx_rd_valid, rx_data, tx_rd_almostfull, tx_wr_almostfull
  );

  modport slave (
    input  rd_valid, rd_addr, wr_valid, wr_addr, wr_data,
    output rx_rd_valid, rx_data, tx_rd_almostfull, tx_wr_almostfull
  );
endinterface

// File: rtl/mem_rd_responder.sv
// In-order DRAM read responder with a local line store; RD_RSP_JITTER_EN adds LFSR pop jitter.
// Latency: LATENCY cycles request-to-response on an empty queue; backlog drains one per cycle.
// Backpressure: registered almostfull at AFULL_THRESH; requests on a full queue are dropped (sticky overflow).
module mem_rd_responder #(
  parameter int ADDR_WIDTH   = 6,
  parameter int LATENCY      = 4,
  parameter int FIFO_AW      = 3,
  parameter int AFULL_THRESH = 6
) (
  input  logic              CLK_400M,
  input  logic              reset_n,
  mem_rd_responder_if.slave bus,
  output logic [FIFO_AW:0]  rd_pending,
  output logic              overflow
);

  localparam int                 DEPTH     = 1 << FIFO_AW;
  localparam int                 LINES     = 1 << ADDR_WIDTH;
  localparam logic [7:0]         ELIG_AGE  = 8'(LATENCY - 1);
  localparam logic [FIFO_AW:0]   AFULL_LVL = (FIFO_AW + 1)'(AFULL_THRESH);
  localparam logic [FIFO_AW:0]   OCC_ONE   = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] idx;
    logic [7:0]            stamp;
  } q_ent_t;

  logic [1:0]            rst_sync;
  logic                  rst_n_int;
  logic [7:0]            stamp_cnt;
  logic [7:0]            head_age;
  q_ent_t                q_mem [DEPTH];
  q_ent_t                head;
  q_ent_t                new_ent;
  logic [FIFO_AW-1:0]    wr_ptr;
  logic [FIFO_AW-1:0]    rd_ptr;
  logic [FIFO_AW:0]      occ;
  logic [FIFO_AW:0]      occ_next;
  logic                  q_full;
  logic                  head_elig;
  logic                  jit_hold;
  logic                  pop_vld;
  logic                  push_vld;
  logic                  drop_vld;
  logic                  wr_bypass;
  logic                  afull;
  logic                  rx_vld;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic [511:0]          line_mem [LINES];
  logic [511:0]          rsp_dat;
  logic [511:0]          rx_dat;
  logic                  unused_addr_hi;

  // Reset asserts asynchronously but releases two clocks after reset_n rises.
  always_ff @(posedge CLK_400M or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n_int = rst_sync[1];

  assign rd_idx         = bus.rd_addr[ADDR_WIDTH-1:0];
  assign wr_idx         = bus.wr_addr[ADDR_WIDTH-1:0];
  assign unused_addr_hi = ^{bus.rd_addr[57:ADDR_WIDTH], bus.wr_addr[57:ADDR_WIDTH]};

`ifdef RD_RSP_JITTER_EN
  logic [15:0] lfsr;

  always_ff @(posedge CLK_400M or negedge rst_n_int) begin
    if (!rst_n_int) lfsr <= 16'hACE1;
    else            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  assign jit_hold = &lfsr[1:0];
`else
  assign jit_hold = 1'b0;
`endif

  // Modular age is safe: no entry can wait 256 cycles at the legal LATENCY/depth limits.
  assign head      = q_mem[rd_ptr];
  assign head_age  = stamp_cnt - head.stamp;
  assign q_full    = occ[FIFO_AW];
  assign head_elig = (occ != '0) && (head_age >= ELIG_AGE);
  assign pop_vld   = head_elig & ~jit_hold;
  assign push_vld  = bus.rd_valid & (~q_full | pop_vld);
  assign drop_vld  = bus.rd_valid & q_full & ~pop_vld;
  assign new_ent   = '{idx: rd_idx, stamp: stamp_cnt};

  // A write landing on the popped line in the same cycle is returned directly.
  assign wr_bypass = bus.wr_valid && (wr_idx == head.idx);
  assign rsp_dat   = wr_bypass ? bus.wr_data : line_mem[head.idx];

  always_comb begin
    occ_next = occ;
    case ({push_vld, pop_vld})
      2'b10:   occ_next = occ + OCC_ONE;
      2'b01:   occ_next = occ - OCC_ONE;
      default: occ_next = occ;
    endcase
  end

  always_ff @(posedge CLK_400M) begin
    if (bus.wr_valid) line_mem[wr_idx] <= bus.wr_data;
    if (push_vld)     q_mem[wr_ptr]    <= new_ent;
  end

  always_ff @(posedge CLK_400M or negedge rst_n_int) begin
    if (!rst_n_int) begin
      stamp_cnt <= 8'd0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      afull     <= 1'b0;
      overflow  <= 1'b0;
      rx_vld    <= 1'b0;
      rx_dat    <= '0;
    end else begin
      stamp_cnt <= stamp_cnt + 8'd1;
      occ       <= occ_next;
      afull     <= (occ_next >= AFULL_LVL);
      rx_vld    <= pop_vld;
      if (push_vld) wr_ptr   <= wr_ptr + PTR_ONE;
      if (pop_vld)  rd_ptr   <= rd_ptr + PTR_ONE;
      if (pop_vld)  rx_dat   <= rsp_dat;
      if (drop_vld) overflow <= 1'b1;
    end
  end

  assign rd_pending           = occ;
  assign bus.rx_rd_valid      = rx_vld;
  assign bus.rx_data          = rx_dat;
  assign bus.tx_rd_almostfull = afull;
  assign bus.tx_wr_almostfull = afull;

endmodule

// File: tb/tb_mem_rd_responder.sv
// Scoreboard bench: instance A runs LATENCY=4, instance B runs LATENCY=20 for overflow/almostfull.
module tb_mem_rd_responder;

  logic       CLK_400M = 1'b0;
  logic       reset_n;
  logic [3:0] pend_a, pend_b;
  logic       ovf_a, ovf_b;

  always #5 CLK_400M = ~CLK_400M;

  mem_rd_responder_if ifa ();
  mem_rd_responder_if ifb ();

  mem_rd_responder #(.ADDR_WIDTH(6), .LATENCY(4), .FIFO_AW(3), .AFULL_THRESH(6)) u_dut_a (
    .CLK_400M(CLK_400M), .reset_n(reset_n), .bus(ifa), .rd_pending(pend_a), .overflow(ovf_a)
  );

  mem_rd_responder #(.ADDR_WIDTH(6), .LATENCY(20), .FIFO_AW(3), .AFULL_THRESH(6)) u_dut_b (
    .CLK_400M(CLK_400M), .reset_n(reset_n), .bus(ifb), .rd_pending(pend_b), .overflow(ovf_b)
  );

  typedef struct {
    logic [511:0] dat;
    int           edge_exp;
  } exp_t;

  exp_t         qa[$];
  exp_t         qb[$];
  int           edge_n = 0;
  int           checks = 0;
  int           errors = 0;
  int           rsp_a  = 0;
  int           rsp_b  = 0;
  int           last_a = -1000;
  int           last_b = -1000;
  logic [511:0] shadow_a [64];
  logic [511:0] shadow_b [64];

  always @(posedge CLK_400M) edge_n <= edge_n + 1;

  task automatic chk_ok(input string name, input bit ok, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    chk_ok(name, act === exp, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK_400M);
    #1;
    ifa.rd_valid = 1'b0;
    ifa.wr_valid = 1'b0;
    ifb.rd_valid = 1'b0;
    ifb.wr_valid = 1'b0;
  endtask

  // Expected response edge: LATENCY after acceptance, but never before the previous response + 1.
  task automatic rd(input bit sel, input int idx, input logic [511:0] dat, input bit track);
    exp_t e;
    e.dat = dat;
    if (sel) begin
      ifb.rd_valid = 1'b1;
      ifb.rd_addr  = {52'hABCDE, 6'(idx)};
      e.edge_exp   = edge_n + 1 + 20;
      if (e.edge_exp <= last_b) e.edge_exp = last_b + 1;
      if (track) begin
        last_b = e.edge_exp;
        qb.push_back(e);
      end
    end else begin
      ifa.rd_valid = 1'b1;
      ifa.rd_addr  = {52'h12345, 6'(idx)};
      e.edge_exp   = edge_n + 1 + 4;
      if (e.edge_exp <= last_a) e.edge_exp = last_a + 1;
      if (track) begin
        last_a = e.edge_exp;
        qa.push_back(e);
      end
    end
  endtask

  task automatic wr(input bit sel, input int idx, input logic [511:0] dat);
    if (sel) begin
      ifb.wr_valid  = 1'b1;
      ifb.wr_addr   = {52'hFFFFF, 6'(idx)};
      ifb.wr_data   = dat;
      shadow_b[idx] = dat;
    end else begin
      ifa.wr_valid  = 1'b1;
      ifa.wr_addr   = {52'h00F0F, 6'(idx)};
      ifa.wr_data   = dat;
      shadow_a[idx] = dat;
    end
  endtask

  task automatic drain(input bit sel, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      if ((sel ? qb.size() : qa.size()) == 0) break;
      tick();
    end
    chk_ok(name, (sel ? qb.size() : qa.size()) == 0, 512'(sel ? qb.size() : qa.size()), 512'd0);
  endtask

  task automatic check_rsp(input string name, input exp_t e, input logic [511:0] dat);
    int resp_edge;
    resp_edge = edge_n + 1;
    chk({name, "_data"}, dat, e.dat);
`ifdef RD_RSP_JITTER_EN
    chk_ok({name, "_edge"}, resp_edge >= e.edge_exp, 512'(resp_edge), 512'(e.edge_exp));
`else
    chk_ok({name, "_edge"}, resp_edge == e.edge_exp, 512'(resp_edge), 512'(e.edge_exp));
`endif
  endtask

  always @(negedge CLK_400M) begin : mon_a
    exp_t e;
    if (ifa.rx_rd_valid === 1'b1) begin
      rsp_a++;
      if (qa.size() == 0) chk_ok("a_unexpected_rsp", 1'b0, 512'd1, 512'd0);
      else begin
        e = qa.pop_front();
        check_rsp("a_rsp", e, ifa.rx_data);
      end
    end
    chk_ok("a_afull", ifa.tx_rd_almostfull === (pend_a >= 4'd6), 512'(ifa.tx_rd_almostfull), 512'(pend_a));
    chk("a_wr_afull", 512'(ifa.tx_wr_almostfull), 512'(ifa.tx_rd_almostfull));
  end

  always @(negedge CLK_400M) begin : mon_b
    exp_t e;
    if (ifb.rx_rd_valid === 1'b1) begin
      rsp_b++;
      if (qb.size() == 0) chk_ok("b_unexpected_rsp", 1'b0, 512'd1, 512'd0);
      else begin
        e = qb.pop_front();
        check_rsp("b_rsp", e, ifb.rx_data);
      end
    end
    chk_ok("b_afull", ifb.tx_rd_almostfull === (pend_b >= 4'd6), 512'(ifb.tx_rd_almostfull), 512'(pend_b));
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at edge %0d", edge_n);
    $fatal(1, "timeout");
  end

  initial begin
    int rsp_base;
    int sent;
    reset_n = 1'b0;
    ifa.rd_valid = 1'b0; ifa.rd_addr = '0; ifa.wr_valid = 1'b0; ifa.wr_addr = '0; ifa.wr_data = '0;
    ifb.rd_valid = 1'b0; ifb.rd_addr = '0; ifb.wr_valid = 1'b0; ifb.wr_addr = '0; ifb.wr_data = '0;
    repeat (3) tick();
    chk("rst_rx_valid", 512'(ifa.rx_rd_valid), 512'd0);
    chk("rst_rx_data", ifa.rx_data, 512'd0);
    chk("rst_afull", 512'(ifa.tx_rd_almostfull), 512'd0);
    chk("rst_pending", 512'(pend_a), 512'd0);
    chk("rst_overflow", 512'(ovf_a), 512'd0);
    reset_n = 1'b1;
    repeat (5) tick();

    // Single read on an empty queue.
    wr(0, 5, {64{8'hA5}}); tick();
    wr(0, 6, {64{8'h5A}}); tick();
    rd(0, 5, {64{8'hA5}}, 1'b1); tick();
    drain(0, 40, "t1_drain");
    chk("t1_pending", 512'(pend_a), 512'd0);

    // Eight back-to-back reads of data == index.
    for (int k = 0; k < 8; k++) begin wr(0, k, 512'(k)); tick(); end
    for (int k = 0; k < 8; k++) begin rd(0, k, shadow_a[k], 1'b1); tick(); end
    drain(0, 60, "t2_drain");
    chk("t2_pending", 512'(pend_a), 512'd0);

`ifndef RD_RSP_JITTER_EN
    // Write landing on the popped line in the pop cycle is bypassed; other indices are not.
    rd(0, 3, 512'h1234, 1'b1); tick();
    tick(); tick();
    wr(0, 3, 512'h1234); tick();
    rd(0, 6, 512'd6, 1'b1); tick();
    tick(); tick();
    wr(0, 7, 512'd777); tick();
    drain(0, 40, "t4_drain");
    rd(0, 3, 512'h1234, 1'b1); tick();
    rd(0, 7, 512'd777, 1'b1); tick();
    drain(0, 40, "t4b_drain");
`endif

    // Long latency: ten reads, last two hit a full queue.
    for (int k = 0; k < 10; k++) begin wr(1, k, 512'(100 + k)); tick(); end
    rsp_base = rsp_b;
    for (int k = 0; k < 10; k++) begin rd(1, k, shadow_b[k], k < 8); tick(); end
    chk("t3_pending_full", 512'(pend_b), 512'd8);
    chk("t3_overflow", 512'(ovf_b), 512'd1);
    chk("t3_afull_high", 512'(ifb.tx_rd_almostfull), 512'd1);
    drain(1, 100, "t3_drain");
    repeat (3) tick();
    chk("t3_overflow_sticky", 512'(ovf_b), 512'd1);
    chk("t3_afull_low", 512'(ifb.tx_rd_almostfull), 512'd0);
    chk("t3_pending_empty", 512'(pend_b), 512'd0);
    chk("t3_rsp_count", 512'(rsp_b - rsp_base), 512'd8);

`ifdef RD_RSP_JITTER_EN
    for (int k = 0; k < 64; k++) begin wr(0, k, 512'(k * 7 + 3)); tick(); end
    rsp_base = rsp_a;
    sent = 0;
    for (int c = 0; c < 2000 && sent < 64; c++) begin
      if (!ifa.tx_rd_almostfull) begin
        rd(0, sent, shadow_a[sent], 1'b1);
        sent++;
      end
      tick();
    end
    chk("t6_sent", 512'(sent), 512'd64);
    drain(0, 400, "t6_drain");
    chk("t6_rsp_count", 512'(rsp_a - rsp_base), 512'd64);
    chk("t6_overflow", 512'(ovf_a), 512'd0);
`endif

    // Reset mid-operation discards everything queued.
    rsp_base = rsp_a;
    for (int k = 0; k < 3; k++) begin rd(0, k, 512'd0, 1'b0); tick(); end
    reset_n = 1'b0;
    #1;
    chk("t5_rx_valid", 512'(ifa.rx_rd_valid), 512'd0);
    chk("t5_rx_data", ifa.rx_data, 512'd0);
    chk("t5_afull", 512'(ifa.tx_rd_almostfull), 512'd0);
    chk("t5_pending", 512'(pend_a), 512'd0);
    chk("t5_overflow_b", 512'(ovf_b), 512'd0);
    @(posedge CLK_400M);
    #1;
    reset_n = 1'b1;
    last_a = -1000;
    last_b = -1000;
    repeat (50) tick();
    chk("t5_no_rsp", 512'(rsp_a - rsp_base), 512'd0);
    chk("t5_pending_after", 512'(pend_a), 512'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
